// File: rtl/apb_cmd_master_pkg.sv
// ecc_apb_pkg: shared types and register map for the APB command master driving the ECC block
package ecc_apb_pkg;
  localparam int AMBA_WORD       = 32;
  localparam int AMBA_ADDR_WIDTH = 20;
  localparam logic [AMBA_ADDR_WIDTH-1:0] CTRL           = 'h0;
  localparam logic [AMBA_ADDR_WIDTH-1:0] DATA_IN        = 'h4;
  localparam logic [AMBA_ADDR_WIDTH-1:0] CODEWORD_WIDTH = 'h8;
  localparam logic [AMBA_ADDR_WIDTH-1:0] NOISE          = 'hC;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, WAIT_DONE} state_t;
  typedef struct packed {
    logic                       write;
    logic [AMBA_ADDR_WIDTH-1:0] addr;
    logic [AMBA_WORD-1:0]       wdata;
  } cmd_t;
endpackage

// File: rtl/apb_cmd_master_if.sv
// apb_cmd_master_if: command queue, read response and APB bus signals of the command master
interface apb_cmd_master_if;
  import ecc_apb_pkg::*;
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_write;
  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr;
  logic [AMBA_WORD-1:0]       cmd_wdata;
  logic                       rsp_valid;
  logic [AMBA_WORD-1:0]       rsp_rdata;
  logic [AMBA_ADDR_WIDTH-1:0] paddr;
  logic                       pwrite;
  logic                       psel;
  logic                       penable;
  logic [AMBA_WORD-1:0]       pwdata;
  logic [AMBA_WORD-1:0]       prdata;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata,
    output cmd_ready, rsp_valid, rsp_rdata, paddr, pwrite, psel, penable, pwdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata,
    input  cmd_ready, rsp_valid, rsp_rdata, paddr, pwrite, psel, penable, pwdata
  );
endinterface

// File: rtl/apb_cmd_master_fifo.sv
// apb_cmd_fifo: command buffer with extra-MSB pointers; full/empty from the MSB compare
module apb_cmd_fifo
  import ecc_apb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  logic i_pop,
  input  cmd_t i_data,
  output cmd_t o_data,
  output logic o_full,
  output logic o_empty
);
  localparam int AW = $clog2(DEPTH);
  cmd_t           r_mem [DEPTH];
  logic [AW:0]    r_wptr;
  logic [AW:0]    r_rptr;
  assign o_empty = r_wptr == r_rptr;
  assign o_full  = r_wptr == {~r_rptr[AW], r_rptr[AW-1:0]};
  assign o_data  = r_mem[r_rptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop) r_rptr <= r_rptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: queued zero-wait APB initiator for the ECC block (SETUP, ACCESS, IDLE per command).
// Define ECC_OPDONE_WAIT_EN to hold after CTRL writes until operation_done or DONE_TIMEOUT.
module apb_cmd_master
  import ecc_apb_pkg::*;
#(
  parameter int                         FIFO_DEPTH   = 4,
  parameter logic [AMBA_ADDR_WIDTH-1:0] CTRL_ADDR    = CTRL,
  parameter int                         DONE_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  apb_cmd_master_if.master        bus,
  input  logic                    i_operation_done,
  output logic                    o_busy,
  output logic                    o_timeout_err
);
  state_t                     r_state;
  state_t                     w_next;
  logic                       w_pop;
  logic                       w_push;
  logic                       w_full;
  logic                       w_empty;
  cmd_t                       w_cmd;
  cmd_t                       w_head;
  logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
  logic                       r_pwrite;
  logic [AMBA_WORD-1:0]       r_pwdata;
  logic                       r_rsp_valid;
  logic [AMBA_WORD-1:0]       r_rsp_rdata;
  logic                       w_timeout;
  assign w_cmd  = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
  assign w_push = bus.cmd_valid && !w_full;
  apb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_cmd),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );
`ifdef ECC_OPDONE_WAIT_EN
  localparam int CW = $clog2(DONE_TIMEOUT);
  logic [CW-1:0] r_cnt;
  logic          r_timeout_err;
  assign w_timeout = r_cnt == CW'(DONE_TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_cnt <= r_state == WAIT_DONE ? r_cnt + 1'b1 : '0;
      if (r_state == WAIT_DONE && !i_operation_done && w_timeout) r_timeout_err <= 1'b1;
    end
  end
  assign o_timeout_err = r_timeout_err;
`else
  logic w_unused;
  assign w_unused      = ^{i_operation_done, CTRL_ADDR, DONE_TIMEOUT};
  assign w_timeout     = 1'b0;
  assign o_timeout_err = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop  = !w_empty;
        w_next = w_empty ? IDLE : SETUP;
      end
      SETUP: w_next = ACCESS;
`ifdef ECC_OPDONE_WAIT_EN
      ACCESS:    w_next = r_pwrite && r_paddr == CTRL_ADDR ? WAIT_DONE : IDLE;
      WAIT_DONE: w_next = i_operation_done || w_timeout ? IDLE : WAIT_DONE;
`else
      ACCESS: w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_next;
      r_rsp_valid <= r_state == ACCESS && !r_pwrite;
      if (r_state == ACCESS && !r_pwrite) r_rsp_rdata <= bus.prdata;
      if (w_pop) begin
        r_paddr  <= w_head.addr;
        r_pwrite <= w_head.write;
        r_pwdata <= w_head.wdata;
      end
    end
  end
  assign bus.cmd_ready = !w_full;
  assign bus.psel      = r_state == SETUP || r_state == ACCESS;
  assign bus.penable   = r_state == ACCESS;
  assign bus.paddr     = r_paddr;
  assign bus.pwrite    = r_pwrite;
  assign bus.pwdata    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign o_busy        = r_state != IDLE || !w_empty;
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: table-driven single transfers plus back-to-back, reset and CTRL-write sequences
module tb_apb_cmd_master;
  import ecc_apb_pkg::*;
  localparam int DONE_TIMEOUT = 1024;
  typedef struct {
    logic        write;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic op_done = 1'b0;
  logic busy;
  logic timeout_err;
  int   checks = 0;
  int   errors = 0;
  int   n_rsp = 0;
  logic was_access = 1'b0;
  logic [19:0] q_acc [$];
  vec_t vecs [5];
  apb_cmd_master_if bus ();
  apb_cmd_master dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .i_operation_done (op_done),
    .o_busy           (busy),
    .o_timeout_err    (timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic w, input logic [19:0] a, input logic [31:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    tick();
    bus.cmd_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (was_access) chk("idle_after_access", bus.psel, 1'b0);
    was_access = bus.psel && bus.penable;
    if (was_access) q_acc.push_back(bus.paddr);
    if (bus.rsp_valid) n_rsp++;
  end
  initial begin
    logic [31:0] exp_rdata;
    logic        rdy;
    int          idx;
    int          guard;
    int          rsp0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.prdata    = '0;
    vecs[0] = '{1'b1, 20'h4, 32'hA5A5_0001, 32'h0};
    vecs[1] = '{1'b0, 20'hC, 32'h0, 32'h0000_00FF};
    vecs[2] = '{1'b1, 20'h8, 32'h0000_0020, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 20'h4, 32'h0, 32'h1234_5678};
    vecs[4] = '{1'b1, 20'hC, 32'h0000_0002, 32'h0};
    #12;
    chk("rst_psel", bus.psel, 1'b0);
    chk("rst_penable", bus.penable, 1'b0);
    chk("rst_paddr", bus.paddr, 20'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    exp_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      bus.prdata = vecs[i].prdata;
      send(vecs[i].write, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("v%0d_queued_psel", i), bus.psel, 1'b0);
      chk($sformatf("v%0d_queued_busy", i), busy, 1'b1);
      tick();
      chk($sformatf("v%0d_setup_psel", i), bus.psel, 1'b1);
      chk($sformatf("v%0d_setup_penable", i), bus.penable, 1'b0);
      chk($sformatf("v%0d_setup_paddr", i), bus.paddr, vecs[i].addr);
      chk($sformatf("v%0d_setup_pwrite", i), bus.pwrite, vecs[i].write);
      if (vecs[i].write) chk($sformatf("v%0d_setup_pwdata", i), bus.pwdata, vecs[i].wdata);
      tick();
      chk($sformatf("v%0d_access_psel", i), bus.psel, 1'b1);
      chk($sformatf("v%0d_access_penable", i), bus.penable, 1'b1);
      tick();
      if (!vecs[i].write) exp_rdata = vecs[i].prdata;
      chk($sformatf("v%0d_idle_psel", i), bus.psel, 1'b0);
      chk($sformatf("v%0d_idle_penable", i), bus.penable, 1'b0);
      chk($sformatf("v%0d_rsp_valid", i), bus.rsp_valid, !vecs[i].write);
      chk($sformatf("v%0d_rsp_rdata", i), bus.rsp_rdata, exp_rdata);
      tick();
      chk($sformatf("v%0d_rsp_once", i), bus.rsp_valid, 1'b0);
      chk($sformatf("v%0d_rdata_held", i), bus.rsp_rdata, exp_rdata);
      chk($sformatf("v%0d_done_busy", i), busy, 1'b0);
    end
    q_acc.delete();
    idx = 0;
    guard = 0;
    while (idx < 6 && guard < 20) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 20'(32'h10 + idx * 4);
      bus.cmd_wdata = 32'(idx);
      rdy = bus.cmd_ready;
      tick();
      if (rdy) idx++;
      guard++;
    end
    bus.cmd_valid = 1'b0;
    chk("b2b_push_cycles", 32'(guard), 32'd6);
    chk("b2b_ready_full", bus.cmd_ready, 1'b0);
    guard = 0;
    while (q_acc.size() < 6 && guard < 100) begin
      tick();
      guard++;
    end
    chk("b2b_drain_in_time", guard < 100, 1'b1);
    chk("b2b_count", 32'(q_acc.size()), 32'd6);
    for (int i = 0; i < 6 && i < q_acc.size(); i++) chk($sformatf("b2b_order%0d", i), q_acc[i], 20'(32'h10 + i * 4));
    tick();
    tick();
    chk("b2b_busy_end", busy, 1'b0);
    chk("b2b_ready_end", bus.cmd_ready, 1'b1);
    bus.prdata = 32'hCAFE_0000;
    rsp0 = n_rsp;
    send(1'b0, 20'h8, 32'h0);
    send(1'b1, 20'hC, 32'h5);
    tick();
    chk("rstacc_psel", bus.psel, 1'b1);
    chk("rstacc_penable", bus.penable, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rstacc_async_psel", bus.psel, 1'b0);
    chk("rstacc_async_penable", bus.penable, 1'b0);
    chk("rstacc_async_rsp", bus.rsp_valid, 1'b0);
    chk("rstacc_async_busy", busy, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rstacc_after_busy", busy, 1'b0);
    chk("rstacc_after_psel", bus.psel, 1'b0);
    chk("rstacc_after_ready", bus.cmd_ready, 1'b1);
    tick();
    chk("rstacc_no_rsp", 32'(n_rsp), 32'(rsp0));
    chk("rstacc_rdata_cleared", bus.rsp_rdata, 32'h0);
    bus.prdata = 32'h0000_0077;
    send(1'b1, CTRL, 32'h2);
    send(1'b0, 20'h4, 32'h0);
    tick();
`ifdef ECC_OPDONE_WAIT_EN
    tick();
    for (int i = 0; i < 19; i++) begin
      chk($sformatf("wait%0d_psel", i), bus.psel, 1'b0);
      chk($sformatf("wait%0d_busy", i), busy, 1'b1);
      tick();
    end
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    chk("done_idle_psel", bus.psel, 1'b0);
    tick();
    chk("done_setup_psel", bus.psel, 1'b1);
    chk("done_setup_paddr", bus.paddr, 20'h4);
    chk("done_setup_pwrite", bus.pwrite, 1'b0);
    repeat (4) tick();
    chk("done_busy_end", busy, 1'b0);
    chk("done_no_timeout", timeout_err, 1'b0);
    send(1'b1, CTRL, 32'h3);
    tick();
    tick();
    tick();
    repeat (DONE_TIMEOUT - 1) tick();
    chk("timeout_not_yet", timeout_err, 1'b0);
    chk("timeout_busy_wait", busy, 1'b1);
    tick();
    chk("timeout_set", timeout_err, 1'b1);
    chk("timeout_busy_end", busy, 1'b0);
    repeat (3) tick();
    chk("timeout_sticky", timeout_err, 1'b1);
`else
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    chk("nowait_idle_psel", bus.psel, 1'b0);
    chk("nowait_idle_busy", busy, 1'b1);
    tick();
    chk("nowait_setup_psel", bus.psel, 1'b1);
    chk("nowait_setup_penable", bus.penable, 1'b0);
    chk("nowait_setup_paddr", bus.paddr, 20'h4);
    chk("nowait_setup_pwrite", bus.pwrite, 1'b0);
    tick();
    tick();
    chk("nowait_rsp_valid", bus.rsp_valid, 1'b1);
    chk("nowait_rsp_rdata", bus.rsp_rdata, 32'h0000_0077);
    tick();
    chk("nowait_busy_end", busy, 1'b0);
    chk("nowait_timeout", timeout_err, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
